// File: rtl/niosii_ms2hw_div9_seq_ctrl.sv
// Avalon-MM sequencer for the constant divide-by-DIVISOR path: accepts operands from
// Nios II or the PIO pins, runs a 1-bit/cycle restoring divider and reports status/IRQ.
module niosii_ms2hw_div9_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  hw_operand,
  input  logic              hw_start,
  output logic [WIDTH-1:0]  quotient,
  output logic [WIDTH-1:0]  remainder,
  output logic              busy,
  output logic              irq
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0]   DIV_EXT  = (WIDTH+1)'(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH:0]     prem_q, prem_d;
  logic [WIDTH-1:0]   quo_acc_q, quo_acc_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               irq_en_q, irq_en_d;

  logic               wr_en;
  logic               ctrl_wr;
  logic               op_wr;
  logic               irqctl_wr;
  logic               av_start;
  logic               start;
  logic               done_set;
  logic               err_set;
  logic [WIDTH:0]     prem_shift;
  logic               sub_ok;
  logic [WIDTH:0]     prem_next;
  logic [WIDTH-1:0]   quo_next;

  always_comb begin
    wr_en     = chipselect & ~write_n;
    ctrl_wr   = wr_en && (address == 2'd0);
    op_wr     = wr_en && (address == 2'd1);
    irqctl_wr = wr_en && (address == 2'd3);
    av_start  = ctrl_wr & writedata[0];
  end

  // One restoring-division step; the partial remainder is always < DIVISOR so the
  // shifted trial value fits in WIDTH+1 bits.
  always_comb begin
    prem_shift = {prem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
    sub_ok     = (prem_shift >= DIV_EXT);
    prem_next  = sub_ok ? (prem_shift - DIV_EXT) : prem_shift;
    quo_next   = (quo_acc_q << 1) | WIDTH'(sub_ok);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dividend_d  = dividend_q;
    prem_d      = prem_q;
    quo_acc_d   = quo_acc_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    operand_d   = operand_q;
    done_d      = done_q;
    err_d       = err_q;
    irq_en_d    = irq_en_q;
    start       = 1'b0;
    done_set    = 1'b0;
    err_set     = 1'b0;

    if (op_wr) begin
      if (state_q == RUN) begin
        err_set = 1'b1;
      end else begin
        operand_d = writedata[WIDTH-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (av_start) begin
          start      = 1'b1;
          dividend_d = operand_q;
          if (hw_start) begin
            err_set = 1'b1;
          end
        end else if (hw_start) begin
          start      = 1'b1;
          dividend_d = hw_operand;
          operand_d  = hw_operand;
        end
        if (start) begin
          prem_d    = '0;
          quo_acc_d = '0;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (av_start || hw_start) begin
          err_set = 1'b1;
        end
        dividend_d = dividend_q << 1;
        prem_d     = prem_next;
        quo_acc_d  = quo_next;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          quotient_d  = quo_next;
          remainder_d = prem_next[WIDTH-1:0];
          done_set    = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Software clears lose to a same-cycle hardware set.
    if (irqctl_wr) begin
      irq_en_d = writedata[0];
      if (writedata[1]) begin
        done_d = 1'b0;
      end
      if (writedata[2]) begin
        err_d = 1'b0;
      end
    end
    if (start) begin
      done_d = 1'b0;
    end
    if (done_set) begin
      done_d = 1'b1;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dividend_q  <= '0;
      prem_q      <= '0;
      quo_acc_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      operand_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dividend_q  <= dividend_d;
      prem_q      <= prem_d;
      quo_acc_q   <= quo_acc_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      operand_q   <= operand_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_en_q    <= irq_en_d;
    end
  end

  always_comb begin
    busy      = (state_q == RUN);
    irq       = done_q & irq_en_q;
    quotient  = quotient_q;
    remainder = remainder_q;
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[2:0] = {err_q, done_q, busy};
      2'd1: readdata[WIDTH-1:0] = operand_q;
      2'd2: begin
        readdata[WIDTH-1:0]  = quotient_q;
        readdata[16 +: WIDTH] = remainder_q;
      end
      2'd3: readdata[0] = irq_en_q;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_niosii_ms2hw_div9_seq_ctrl.sv
// Scoreboard bench for the divide-by-9 sequencer: expected results are queued at start,
// a monitor checks them whenever busy drops.
module tb_niosii_ms2hw_div9_seq_ctrl;

  localparam int WIDTH = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [WIDTH-1:0]  hw_operand = '0;
  logic              hw_start = 1'b0;
  logic [WIDTH-1:0]  quotient;
  logic [WIDTH-1:0]  remainder;
  logic              busy;
  logic              irq;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   fails = 0;
  int   busyCnt = 0;
  logic busyPrev = 1'b0;

  niosii_ms2hw_div9_seq_ctrl #(.WIDTH(WIDTH), .DIVISOR(9)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hw_operand (hw_operand),
    .hw_start   (hw_start),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: each busy falling edge is a completion to be matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      busyPrev = 1'b0;
      busyCnt  = 0;
    end else begin
      if (busy) begin
        busyCnt++;
      end else if (busyPrev) begin
        check("busy_len", busyCnt, 8);
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_result: got q=%0d r=%0d, expected no completion", quotient, remainder);
        end else begin
          e = expQ.pop_front();
          check("quotient", {24'd0, quotient}, {24'd0, e.q});
          check("remainder", {24'd0, remainder}, {24'd0, e.r});
        end
        busyCnt = 0;
      end
      busyPrev = busy;
    end
  end

  task automatic avWrite(input logic [1:0] addr, input logic [31:0] data, input logic hw = 1'b0);
    @(negedge clk);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    hw_start   = hw;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    hw_start   = 1'b0;
  endtask

  task automatic avRead(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    data       = readdata;
    chipselect = 1'b0;
  endtask

  task automatic applyStart(input logic [7:0] op, input logic [7:0] q, input logic [7:0] r);
    exp_t e;
    avWrite(2'd1, {24'd0, op});
    avWrite(2'd0, 32'd1);
    e.q = q;
    e.r = r;
    expQ.push_back(e);
  endtask

  task automatic hwPulse(input logic [7:0] op);
    @(negedge clk);
    hw_operand = op;
    hw_start   = 1'b1;
    @(posedge clk);
    #1;
    hw_start   = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic readCheck(input logic [1:0] addr, input string name, input logic [31:0] exp);
    logic [31:0] d;
    avRead(addr, d);
    check(name, d, exp);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no end of test, expected $finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] dirOp[4] = '{8'd0, 8'd8, 8'd9, 8'd255};
    logic [7:0] dirQ[4]  = '{8'd0, 8'd0, 8'd1, 8'd28};
    logic [7:0] dirR[4]  = '{8'd0, 8'd8, 8'd0, 8'd3};

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_quotient", {24'd0, quotient}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    readCheck(2'd0, "rst_status", 0);
    readCheck(2'd1, "rst_operand", 0);
    readCheck(2'd2, "rst_result", 0);
    readCheck(2'd3, "rst_irqctl", 0);

    // 100 / 9 with latency checks around E8
    applyStart(8'd100, 8'd11, 8'd1);
    repeat (7) @(posedge clk);
    readCheck(2'd0, "lat_e7_status", 32'd1);
    @(posedge clk);
    readCheck(2'd0, "lat_e8_status", 32'd2);
    readCheck(2'd2, "result_100", 32'h0001_000B);

    // START while DONE=1 clears DONE at E0
    applyStart(8'd8, 8'd0, 8'd8);
    readCheck(2'd0, "done_cleared_on_start", 32'd1);
    waitIdle();

    for (int i = 0; i < 4; i++) begin
      applyStart(dirOp[i], dirQ[i], dirR[i]);
      waitIdle();
    end
    readCheck(2'd2, "result_255", 32'h0003_001C);

    for (int i = 0; i < 256; i++) begin
      applyStart(8'(i), 8'(i / 9), 8'(i % 9));
      waitIdle();
    end

    // Operand from the hardware pins
    hwPulse(8'd81);
    begin
      exp_t e;
      e.q = 8'd9;
      e.r = 8'd0;
      expQ.push_back(e);
    end
    waitIdle();
    readCheck(2'd1, "hw_operand_copied", 32'd81);

    // START and OPERAND write during a running op
    applyStart(8'd100, 8'd11, 8'd1);
    repeat (2) @(posedge clk);
    avWrite(2'd0, 32'd1);
    avWrite(2'd1, 32'd55);
    waitIdle();
    readCheck(2'd0, "err_busy_start", 32'd6);
    readCheck(2'd1, "operand_kept", 32'd100);
    readCheck(2'd2, "result_intact", 32'h0001_000B);
    avWrite(2'd3, 32'd6);
    readCheck(2'd0, "status_cleared", 32'd0);

    // Avalon START and hw_start together: Avalon operand wins
    avWrite(2'd1, 32'd9);
    hw_operand = 8'd81;
    avWrite(2'd0, 32'd1, 1'b1);
    begin
      exp_t e;
      e.q = 8'd1;
      e.r = 8'd0;
      expQ.push_back(e);
    end
    waitIdle();
    readCheck(2'd0, "err_same_cycle", 32'd6);
    readCheck(2'd1, "operand_same_cycle", 32'd9);
    avWrite(2'd3, 32'd6);

    // hw_start while busy is ignored
    applyStart(8'd8, 8'd0, 8'd8);
    repeat (2) @(posedge clk);
    hwPulse(8'd200);
    waitIdle();
    readCheck(2'd0, "err_hw_busy", 32'd6);
    avWrite(2'd3, 32'd6);

    // START=0 does nothing
    avWrite(2'd0, 32'd0);
    check("start0_busy", {31'd0, busy}, 0);
    readCheck(2'd0, "start0_status", 32'd0);

    // IRQ behaviour
    avWrite(2'd3, 32'd1);
    readCheck(2'd3, "irq_en_read", 32'd1);
    applyStart(8'd255, 8'd28, 8'd3);
    waitIdle();
    check("irq_on_done", {31'd0, irq}, 1);
    avWrite(2'd3, 32'd3);
    check("irq_after_clear", {31'd0, irq}, 0);
    applyStart(8'd9, 8'd1, 8'd0);
    repeat (7) @(posedge clk);
    avWrite(2'd3, 32'd3);
    check("irq_set_wins", {31'd0, irq}, 1);
    readCheck(2'd0, "done_set_wins", 32'd2);
    avWrite(2'd3, 32'd2);
    applyStart(8'd100, 8'd11, 8'd1);
    waitIdle();
    check("irq_disabled", {31'd0, irq}, 0);
    readCheck(2'd0, "done_without_irq", 32'd2);

    // Reset in the middle of a run
    avWrite(2'd1, 32'd200);
    avWrite(2'd0, 32'd1);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    address = 2'd0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_quotient", {24'd0, quotient}, 0);
    check("rst_mid_remainder", {24'd0, remainder}, 0);
    check("rst_mid_status", readdata, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStart(8'd200, 8'd22, 8'd2);
    waitIdle();
    readCheck(2'd0, "post_reset_status", 32'd2);

    repeat (3) @(negedge clk);
    check("queue_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
